dfr_batch_controller: RTL

Sequences the delayed-feedback-reservoir datapath for a batch of N samples per start command. For each sample it runs reservoir init (optional), reservoir run and matrix multiply, with a per-stage watchdog, an abort input and an error code. It sits between the host register file and the reservoir/matrix-multiply engines, and is the multi-sample successor to the single-shot core controller.

---
 rtl/dfr_ctrl_pkg.sv | 23 ++
 rtl/dfr_stage_watchdog.sv | 40 ++++
 rtl/dfr_batch_controller.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/dfr_ctrl_pkg.sv
// Shared types and default widths for the delayed-feedback-reservoir batch controller.
package dfr_ctrl_pkg;

    localparam int DFR_SAMPLE_CNT_WIDTH = 16;
    localparam int DFR_TIMEOUT_WIDTH    = 20;
    localparam int DFR_TIMEOUT_CYCLES   = 100000;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RES_INIT = 3'd1,
        RES_RUN  = 3'd2,
        MM_RUN   = 3'd3,
        ADVANCE  = 3'd4,
        FINISH   = 3'd5
    } dfr_batch_state_t;

    typedef enum logic [1:0] {
        DFR_ERR_NONE    = 2'd0,
        DFR_ERR_TIMEOUT = 2'd1,
        DFR_ERR_ABORT   = 2'd2
    } dfr_err_t;

endpackage

// File: rtl/dfr_stage_watchdog.sv
// Per-stage cycle counter; expired_o flags the last allowed cycle of a stage.
module dfr_stage_watchdog
    import dfr_ctrl_pkg::*;
#(
    parameter int TIMEOUT_WIDTH  = DFR_TIMEOUT_WIDTH,
    parameter int TIMEOUT_CYCLES = DFR_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [TIMEOUT_WIDTH-1:0] LAST_COUNT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_WIDTH-1:0] count_q;
    logic [TIMEOUT_WIDTH-1:0] count_d;

    // Saturates at LAST_COUNT so a disabled watchdog can never wrap.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LAST_COUNT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (TIMEOUT_CYCLES != 0) && (count_q == LAST_COUNT);

endmodule

// File: rtl/dfr_batch_controller.sv
// Batch sequencer for the reservoir datapath: per sample runs init (optional), run and
// matrix multiply, with watchdog, abort and a sticky error code.
module dfr_batch_controller
    import dfr_ctrl_pkg::*;
#(
    parameter int SAMPLE_CNT_WIDTH = DFR_SAMPLE_CNT_WIDTH,
    parameter int TIMEOUT_WIDTH    = DFR_TIMEOUT_WIDTH,
    parameter int TIMEOUT_CYCLES   = DFR_TIMEOUT_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [SAMPLE_CNT_WIDTH-1:0] num_samples,
    input  logic                        reinit_each_sample,
    input  logic                        reservoir_init_busy,
    input  logic                        reservoir_busy,
    input  logic                        reservoir_filled,
    input  logic                        matrix_multiply_busy,
    output logic                        busy,
    output logic                        reservoir_rst,
    output logic                        matrix_multiply_rst,
    output logic                        matrix_multiply_start,
    output logic                        reservoir_en,
    output logic                        reservoir_history_en,
    output logic                        sample_cntr_rst,
    output logic [SAMPLE_CNT_WIDTH-1:0] sample_idx,
    output logic                        sample_done,
    output logic                        dfr_done,
    output logic [1:0]                  err_code
);

    dfr_batch_state_t state_q, state_d;
    dfr_err_t         err_q, err_d;
    logic [SAMPLE_CNT_WIDTH-1:0] count_q, count_d, idx_q, idx_d;
    logic reinit_q, reinit_d;
    logic entry_q;
    logic res_rst_q, res_rst_d, mm_rst_q, mm_rst_d, mm_start_q, mm_start_d;
    logic scr_q, scr_d, sample_done_q, sample_done_d, dfr_done_q, dfr_done_d;
    logic in_stage, stage_busy, expired;

    assign in_stage = (state_q == RES_INIT) || (state_q == RES_RUN) || (state_q == MM_RUN);

    always_comb begin
        stage_busy = 1'b0;
        case (state_q)
            RES_INIT: stage_busy = reservoir_init_busy;
            RES_RUN:  stage_busy = reservoir_busy;
            MM_RUN:   stage_busy = matrix_multiply_busy;
            default:  stage_busy = 1'b0;
        endcase
    end

    dfr_stage_watchdog #(
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (state_d != state_q),
        .enable_i (in_stage),
        .expired_o(expired)
    );

    // Abort outranks timeout, which outranks normal stage completion.
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        count_d    = count_q;
        idx_d      = idx_q;
        reinit_d   = reinit_q;
        res_rst_d  = 1'b0;
        mm_rst_d   = 1'b0;
        mm_start_d = 1'b0;
        scr_d      = 1'b0;
        if (abort && (state_q != IDLE) && (state_q != FINISH)) begin
            err_d     = DFR_ERR_ABORT;
            res_rst_d = 1'b1;
            mm_rst_d  = 1'b1;
            state_d   = FINISH;
        end else if (in_stage && expired && stage_busy) begin
            err_d     = DFR_ERR_TIMEOUT;
            res_rst_d = 1'b1;
            mm_rst_d  = 1'b1;
            state_d   = FINISH;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        err_d = DFR_ERR_NONE;
                        idx_d = '0;
                        if (num_samples != '0) begin
                            count_d   = num_samples;
                            reinit_d  = reinit_each_sample;
                            res_rst_d = 1'b1;
                            mm_rst_d  = 1'b1;
                            scr_d     = 1'b1;
                            state_d   = RES_INIT;
                        end else begin
                            state_d = FINISH;
                        end
                    end
                end
                RES_INIT: begin
                    if (!entry_q && !stage_busy) begin
                        scr_d   = 1'b1;
                        state_d = RES_RUN;
                    end
                end
                RES_RUN: begin
                    if (!entry_q && !stage_busy) begin
                        mm_start_d = 1'b1;
                        state_d    = MM_RUN;
                    end
                end
                MM_RUN: begin
                    if (!entry_q && !stage_busy) begin
                        state_d = ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (idx_q == (count_q - SAMPLE_CNT_WIDTH'(1))) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        scr_d   = 1'b1;
                        state_d = reinit_q ? RES_INIT : RES_RUN;
                    end
                end
                FINISH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        // ADVANCE and FINISH are single-cycle, so entering them is exactly their entry cycle.
        sample_done_d = (state_d == ADVANCE);
        dfr_done_d    = (state_d == FINISH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            err_q         <= DFR_ERR_NONE;
            count_q       <= '0;
            idx_q         <= '0;
            reinit_q      <= 1'b0;
            entry_q       <= 1'b0;
            res_rst_q     <= 1'b0;
            mm_rst_q      <= 1'b0;
            mm_start_q    <= 1'b0;
            scr_q         <= 1'b0;
            sample_done_q <= 1'b0;
            dfr_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            err_q         <= err_d;
            count_q       <= count_d;
            idx_q         <= idx_d;
            reinit_q      <= reinit_d;
            entry_q       <= (state_d != state_q);
            res_rst_q     <= res_rst_d;
            mm_rst_q      <= mm_rst_d;
            mm_start_q    <= mm_start_d;
            scr_q         <= scr_d;
            sample_done_q <= sample_done_d;
            dfr_done_q    <= dfr_done_d;
        end
    end

    assign busy                  = (state_q != IDLE);
    assign reservoir_en          = (state_q == RES_INIT) || (state_q == RES_RUN);
    assign reservoir_history_en  = (state_q == RES_RUN) && reservoir_filled;
    assign reservoir_rst         = res_rst_q;
    assign matrix_multiply_rst   = mm_rst_q;
    assign matrix_multiply_start = mm_start_q;
    assign sample_cntr_rst       = scr_q;
    assign sample_idx            = idx_q;
    assign sample_done           = sample_done_q;
    assign dfr_done              = dfr_done_q;
    assign err_code              = err_q;

endmodule
